qubit_measure_sift: RTL and testbench

- Receiver-side (Bob) counterpart of the polarization encoder.
- Takes a frame of N 2-bit polarization codes and Bob's random measurement bases, and measures each qubit in Bob's basis; a basis mismatch gives a pseudo-random outcome.
- After Alice's public basis announcement, sifts the frame: keeps only positions where the two bases agree.
- Streams sifted bits over a valid/ready interface and also presents the full sifted key and its length for the downstream error-correction stage.

---
 rtl/qkd_pkg.sv | 38 +++
 rtl/qkd_lfsr16.sv | 33 +++
 rtl/qubit_measure_sift.sv | 153 +++++++++++++++
 tb/tb_qubit_measure_sift.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/qkd_pkg.sv
// Shared QKD definitions: polarization codes, sifter FSM states, and the LFSR taps and default seed.
package qkd_pkg;

  localparam int unsigned LFSR_W = 16;

  // Polarization codes {basis, value}; the encoder uses the same codes.
  localparam logic [1:0] ZERO         = 2'b00;
  localparam logic [1:0] NINETY       = 2'b01;
  localparam logic [1:0] FORTYFIVE    = 2'b10;
  localparam logic [1:0] ONETHREEFIVE = 2'b11;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form: feedback = s[0]^s[2]^s[3]^s[5].
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } sift_state_t;

  // Measure one qubit in basis 'base'; a basis mismatch returns the random bit 'rnd'.
  function automatic logic pol_measure(input logic [1:0] code, input logic base, input logic rnd);
    logic pb;
    logic pv;
    pb = code[1];
    pv = code[0];
    case (code)
      ZERO:         begin pb = 1'b0; pv = 1'b0; end
      NINETY:       begin pb = 1'b0; pv = 1'b1; end
      FORTYFIVE:    begin pb = 1'b1; pv = 1'b0; end
      ONETHREEFIVE: begin pb = 1'b1; pv = 1'b1; end
    endcase
    return (base == pb) ? pv : rnd;
  endfunction

endpackage

// File: rtl/qkd_lfsr16.sv
// 16-bit Fibonacci LFSR with advance enable and seed load; a zero seed is replaced by the default.
module qkd_lfsr16
  import qkd_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb    = ^(r_state & LFSR_TAPS);
  assign o_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_SAFE;
    end else if (i_load) begin
      r_state <= (i_seed == 16'h0000) ? LFSR_DEFAULT_SEED : i_seed;
    end else if (i_en) begin
      r_state <= {w_fb, r_state[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/qubit_measure_sift.sv
// Bob-side qubit measurement and basis sifting with valid/ready streaming of sifted bits.
// Optional: define DISCARD_CNT_EN to add the discard_cnt output (count of basis-mismatch positions).
module qubit_measure_sift
  import qkd_pkg::*;
#(
  parameter int unsigned N         = 80,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2*N-1:0]           qubit,
  input  logic [N-1:0]             bob_base,
  input  logic [N-1:0]             alice_base,
  output logic                     busy,
  output logic                     out_valid,
  output logic                     out_bit,
  input  logic                     out_ready,
  output logic [N-1:0]             meas_bits,
  output logic [N-1:0]             sift_key,
  output logic [$clog2(N+1)-1:0]   sift_len,
  output logic                     done
`ifdef DISCARD_CNT_EN
  ,
  output logic [$clog2(N+1)-1:0]   discard_cnt
`endif
);

  localparam int unsigned LEN_W = $clog2(N + 1);
  localparam int unsigned IDX_W = $clog2(N + 1);

  sift_state_t       r_state, w_state_nxt;
  logic [2*N-1:0]    r_q;
  logic [N-1:0]      r_bb, r_ab;
  logic [IDX_W-1:0]  r_idx;
  logic [N-1:0]      r_meas, r_key;
  logic [LEN_W-1:0]  r_len;
  logic              r_out_valid, r_out_bit, r_done, r_busy;
  logic              w_done_nxt, w_busy_nxt;
  logic              w_capture, w_hs, w_stall, w_proc, w_last, w_sift, w_meas;
  logic [1:0]        w_code;
  logic [IDX_W:0]    w_qbase;
  logic [15:0]       w_lfsr;

  assign w_capture = (r_state == IDLE) && start;
  assign w_hs      = r_out_valid && out_ready;
  assign w_stall   = r_out_valid && !out_ready;
  assign w_proc    = (r_state == MEASURE) && !w_stall;
  assign w_last    = (r_idx == IDX_W'(N - 1));
  assign w_qbase   = {r_idx, 1'b0};
  assign w_code    = r_q[w_qbase +: 2];
  assign w_sift    = (r_ab[r_idx] == r_bb[r_idx]);
  assign w_meas    = pol_measure(w_code, r_bb[r_idx], w_lfsr[0]);

  // Mismatch-outcome generator: advances only on processed positions.
  qkd_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_proc),
    .i_load  (1'b0),
    .i_seed  (LFSR_SEED),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_nxt = MEASURE;
      MEASURE: if (w_proc && w_last) w_state_nxt = FLUSH;
      FLUSH:   if (!r_out_valid || w_hs) w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // Frame capture, per-position measurement/sifting and the output stream register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_bb        <= '0;
      r_ab        <= '0;
      r_idx       <= '0;
      r_meas      <= '0;
      r_key       <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
    end else if (w_capture) begin
      r_q    <= qubit;
      r_bb   <= bob_base;
      r_ab   <= alice_base;
      r_idx  <= '0;
      r_meas <= '0;
      r_key  <= '0;
      r_len  <= '0;
    end else if (w_proc) begin
      r_meas[r_idx] <= w_meas;
      r_idx         <= r_idx + 1'b1;
      if (w_sift) begin
        r_key[r_len[IDX_W-1:0]] <= w_meas;
        r_len                   <= r_len + 1'b1;
        r_out_valid             <= 1'b1;
        r_out_bit               <= w_meas;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DISCARD_CNT_EN
  logic [LEN_W-1:0] r_disc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disc <= '0;
    end else if (w_capture) begin
      r_disc <= '0;
    end else if (w_proc && !w_sift) begin
      r_disc <= r_disc + 1'b1;
    end
  end

  assign discard_cnt = r_disc;
`endif

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign meas_bits = r_meas;
  assign sift_key  = r_key;
  assign sift_len  = r_len;
  assign done      = r_done;

endmodule

// File: tb/tb_qubit_measure_sift.sv
// Directed self-checking bench for qubit_measure_sift (with DISCARD_CNT_EN it also checks discard_cnt).
module tb_qubit_measure_sift;

  localparam int N  = 80;
  localparam int LW = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] qubit = '0;
  logic [N-1:0]   bob_base = '0;
  logic [N-1:0]   alice_base = '0;
  logic           out_ready = 1'b1;
  logic           busy, out_valid, out_bit, done;
  logic [N-1:0]   meas_bits, sift_key;
  logic [LW-1:0]  sift_len;
`ifdef DISCARD_CNT_EN
  logic [LW-1:0]  discard_cnt;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  // Frame results collected by run_frame
  int          r_done_cyc, r_stalls, r_beats;
  logic [N-1:0] r_bits;
  bit          r_stable;

  qubit_measure_sift dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .qubit      (qubit),
    .bob_base   (bob_base),
    .alice_base (alice_base),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_ready  (out_ready),
    .meas_bits  (meas_bits),
    .sift_key   (sift_key),
    .sift_len   (sift_len),
    .done       (done)
`ifdef DISCARD_CNT_EN
    ,
    .discard_cnt(discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11 as right-shift with feedback from bits 0,2,3,5.
  function automatic logic [N-1:0] model_bits(input logic [15:0] s);
    logic [N-1:0] b;
    logic         fb;
    for (int i = 0; i < N; i++) begin
      b[i] = s[0];
      fb   = s[0] ^ s[2] ^ s[3] ^ s[5];
      s    = {fb, s[15:1]};
    end
    return b;
  endfunction

  function automatic logic [15:0] model_adv(input logic [15:0] s);
    logic fb;
    for (int i = 0; i < N; i++) begin
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      s  = {fb, s[15:1]};
    end
    return s;
  endfunction

  // Starts a frame, streams it out and records done cycle, stalls and beats.
  task automatic run_frame(input logic [2*N-1:0] q, input logic [N-1:0] bb, input logic [N-1:0] ab,
                           input bit toggle, input int restart_at);
    logic stall_prev;
    logic stall_bit;
    qubit = q; bob_base = bb; alice_base = ab; out_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    r_done_cyc = -1; r_stalls = 0; r_beats = 0; r_bits = '0; r_stable = 1'b1;
    stall_prev = 1'b0; stall_bit = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      out_ready = toggle ? c[0] : 1'b1;
      if (c == restart_at) begin
        start = 1'b1; qubit = ~q; bob_base = ~bb; alice_base = ~ab;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (r_beats < N) r_bits[r_beats] = out_bit;
        r_beats++;
      end else if (out_valid && !out_ready) begin
        r_stalls++;
      end
      stall_prev = out_valid && !out_ready;
      stall_bit  = out_bit;
      @(posedge clk);
      #1;
      if (stall_prev && (!out_valid || out_bit !== stall_bit)) r_stable = 1'b0;
      if (done) begin
        r_done_cyc = c;
        break;
      end
    end
    start = 1'b0; qubit = q; bob_base = bb; alice_base = ab; out_ready = 1'b1;
    m_lfsr = model_adv(m_lfsr);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (out_valid !== 1'b0 || out_bit !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl got v=%b b=%b d=%b exp 0 0 0", out_valid, out_bit, done); end
    n_cmp++; if (meas_bits !== '0 || sift_key !== '0 || sift_len !== '0) begin
      n_err++; $display("FAIL reset_data got m=%h k=%h l=%0d exp 0", meas_bits, sift_key, sift_len); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_no_sift(input string tag);
    logic [N-1:0] exp_m;
    exp_m = model_bits(m_lfsr);
    run_frame('0, '1, '0, 1'b0, -1);
    n_cmp++; if (r_done_cyc !== 82) begin n_err++; $display("FAIL %s_done_cyc got %0d exp 82", tag, r_done_cyc); end
    n_cmp++; if (meas_bits !== exp_m) begin n_err++; $display("FAIL %s_meas got %h exp %h", tag, meas_bits, exp_m); end
    n_cmp++; if (sift_len !== 7'd0 || sift_key !== '0) begin
      n_err++; $display("FAIL %s_sift got l=%0d k=%h exp 0", tag, sift_len, sift_key); end
    n_cmp++; if (r_beats !== 0) begin n_err++; $display("FAIL %s_beats got %0d exp 0", tag, r_beats); end
`ifdef DISCARD_CNT_EN
    n_cmp++; if (discard_cnt !== 7'd80) begin n_err++; $display("FAIL %s_discard got %0d exp 80", tag, discard_cnt); end
`endif
  endtask

  task automatic test_all_sift();
    run_frame({N{2'b01}}, '0, '0, 1'b0, -1);
    n_cmp++; if (r_done_cyc !== 82) begin n_err++; $display("FAIL all_done_cyc got %0d exp 82", r_done_cyc); end
    n_cmp++; if (sift_len !== 7'd80) begin n_err++; $display("FAIL all_len got %0d exp 80", sift_len); end
    n_cmp++; if (sift_key !== {N{1'b1}} || meas_bits !== {N{1'b1}}) begin
      n_err++; $display("FAIL all_key got k=%h m=%h exp all ones", sift_key, meas_bits); end
    n_cmp++; if (r_beats !== 80 || r_bits !== {N{1'b1}}) begin
      n_err++; $display("FAIL all_stream got n=%0d bits=%h exp 80 all ones", r_beats, r_bits); end
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL all_idle got busy=%b v=%b exp 0 0", busy, out_valid); end
`ifdef DISCARD_CNT_EN
    n_cmp++; if (discard_cnt !== 7'd0) begin n_err++; $display("FAIL all_discard got %0d exp 0", discard_cnt); end
`endif
  endtask

  task automatic test_alternate(input string tag, input int restart_at);
    run_frame({40{4'b1110}}, '1, {40{2'b01}}, 1'b0, restart_at);
    n_cmp++; if (r_done_cyc !== 82) begin n_err++; $display("FAIL %s_done_cyc got %0d exp 82", tag, r_done_cyc); end
    n_cmp++; if (sift_len !== 7'd40) begin n_err++; $display("FAIL %s_len got %0d exp 40", tag, sift_len); end
    n_cmp++; if (meas_bits !== {40{2'b10}}) begin
      n_err++; $display("FAIL %s_meas got %h exp %h", tag, meas_bits, {40{2'b10}}); end
    n_cmp++; if (sift_key !== '0 || r_beats !== 40 || r_bits !== '0) begin
      n_err++; $display("FAIL %s_stream got k=%h n=%0d bits=%h exp 0 40 0", tag, sift_key, r_beats, r_bits); end
`ifdef DISCARD_CNT_EN
    n_cmp++; if (discard_cnt !== 7'd40) begin n_err++; $display("FAIL %s_discard got %0d exp 40", tag, discard_cnt); end
`endif
  endtask

  task automatic test_stall();
    run_frame({N{2'b01}}, '0, '0, 1'b1, -1);
    n_cmp++; if (r_stalls !== 80) begin n_err++; $display("FAIL stall_count got %0d exp 80", r_stalls); end
    n_cmp++; if (r_done_cyc !== 162) begin n_err++; $display("FAIL stall_done_cyc got %0d exp 162", r_done_cyc); end
    n_cmp++; if (r_stable !== 1'b1) begin n_err++; $display("FAIL stall_stable got %b exp 1", r_stable); end
    n_cmp++; if (r_beats !== 80 || r_bits !== {N{1'b1}} || sift_len !== 7'd80) begin
      n_err++; $display("FAIL stall_stream got n=%0d bits=%h l=%0d exp 80 ones 80", r_beats, r_bits, sift_len); end
    test_no_sift("stall_lfsr");
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    qubit = {N{2'b01}}; bob_base = '0; alice_base = '0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_bit !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ctrl got busy=%b v=%b b=%b d=%b exp 0", busy, out_valid, out_bit, done); end
    n_cmp++; if (meas_bits !== '0 || sift_key !== '0 || sift_len !== '0) begin
      n_err++; $display("FAIL mid_rst_data got m=%h k=%h l=%0d exp 0", meas_bits, sift_key, sift_len); end
    m_lfsr = 16'hACE1;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_no_done got %b exp 0", saw_done); end
    test_no_sift("post_rst");
  endtask

  initial begin
    test_reset();
    test_no_sift("no_sift");
    test_all_sift();
    test_alternate("alt", -1);
    test_stall();
    test_alternate("start_busy", 10);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
